// File: rtl/chacha_host_seq.sv
// chacha_host_seq: host-side initiator for the ChaCha core register/round port.
// Collects a 64-byte state image, writes it to core words 0..15, runs the core
// for ROUNDS cycles, then reads the 16 result words back as a 64-byte stream.
//
// Handshake: a byte moves on the input side when in_valid && in_ready, and on
// the output side when out_valid && out_ready, both sampled at the rising edge.
// out_byte is held stable while out_valid && !out_ready; in_ready is a pure
// function of the current state and never depends on in_valid.
module chacha_host_seq #(
  parameter int unsigned ROUNDS   = 20,
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        abort,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [3:0]  core_addr,
  output logic [31:0] core_data_in,
  output logic        core_write_n,
  output logic        core_round_n,
  input  logic [31:0] core_data_out
);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_WRITE = 3'd1,
    S_ROUND = 3'd2,
    S_RADDR = 3'd3,
    S_RWAIT = 3'd4,
    S_EMIT  = 3'd5
  } state_t;

  // Last value of the round counter before leaving ROUND.
  localparam logic [7:0] RLAST = 8'(ROUNDS - 1);
  // Number of wait cycles between address and read-data capture.
  localparam logic [1:0] RLAT  = 2'(READ_LAT);

  state_t      state;
  logic [1:0]  bcnt;      // byte position within the word being loaded
  logic [3:0]  widx;      // next core word to write
  logic [7:0]  rcnt;      // round cycles already issued
  logic [3:0]  ridx;      // core word being read back
  logic [1:0]  lcnt;      // read-latency wait counter
  logic [1:0]  kidx;      // byte position within the word being emitted
  logic [23:0] word_buf;  // lower three bytes of the word being loaded
  logic [31:0] out_word;  // captured read word

  logic       in_fire;
  logic       out_fire;
  logic [1:0] kidx_nxt;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state != S_LOAD);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign kidx_nxt = kidx + 2'd1;

  // Sequencer: load/write/round/read/emit with abort taking priority over all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_LOAD;
      bcnt         <= 2'd0;
      widx         <= 4'd0;
      rcnt         <= 8'd0;
      ridx         <= 4'd0;
      lcnt         <= 2'd0;
      kidx         <= 2'd0;
      word_buf     <= 24'd0;
      out_word     <= 32'd0;
      out_byte     <= 8'd0;
      out_valid    <= 1'b0;
      done         <= 1'b0;
      core_addr    <= 4'd0;
      core_data_in <= 32'd0;
      core_write_n <= 1'b1;
      core_round_n <= 1'b1;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Drop everything, including a byte offered in this same cycle.
        state        <= S_LOAD;
        bcnt         <= 2'd0;
        widx         <= 4'd0;
        rcnt         <= 8'd0;
        ridx         <= 4'd0;
        lcnt         <= 2'd0;
        kidx         <= 2'd0;
        word_buf     <= 24'd0;
        out_valid    <= 1'b0;
        core_addr    <= 4'd0;
        core_write_n <= 1'b1;
        core_round_n <= 1'b1;
      end else begin
        case (state)
          S_LOAD: begin
            if (in_fire) begin
              bcnt <= bcnt + 2'd1;
              case (bcnt)
                2'd0: word_buf[7:0]   <= in_byte;
                2'd1: word_buf[15:8]  <= in_byte;
                2'd2: word_buf[23:16] <= in_byte;
                2'd3: begin
                  // Little-endian: the fourth byte lands in the top lane.
                  core_data_in <= {in_byte, word_buf};
                  core_addr    <= widx;
                  core_write_n <= 1'b0;
                  state        <= S_WRITE;
                end
                default: word_buf <= word_buf;
              endcase
            end
          end

          S_WRITE: begin
            // Single-cycle write strobe, then either more loading or rounds.
            core_write_n <= 1'b1;
            widx         <= widx + 4'd1;
            if (widx == 4'd15) begin
              core_round_n <= 1'b0;
              rcnt         <= 8'd0;
              state        <= S_ROUND;
            end else begin
              state <= S_LOAD;
            end
          end

          S_ROUND: begin
            if (rcnt == RLAST) begin
              core_round_n <= 1'b1;
              rcnt         <= 8'd0;
              ridx         <= 4'd0;
              core_addr    <= 4'd0;
              state        <= S_RADDR;
            end else begin
              rcnt <= rcnt + 8'd1;
            end
          end

          S_RADDR: begin
            if (READ_LAT == 0) begin
              // Combinational-read core: data is valid alongside the address.
              out_word  <= core_data_out;
              out_byte  <= core_data_out[7:0];
              kidx      <= 2'd0;
              lcnt      <= 2'd0;
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end else begin
              lcnt  <= 2'd1;
              state <= S_RWAIT;
            end
          end

          S_RWAIT: begin
            if (lcnt == RLAT) begin
              out_word  <= core_data_out;
              out_byte  <= core_data_out[7:0];
              kidx      <= 2'd0;
              lcnt      <= 2'd0;
              out_valid <= 1'b1;
              state     <= S_EMIT;
            end else begin
              lcnt <= lcnt + 2'd1;
            end
          end

          S_EMIT: begin
            if (out_fire) begin
              if (kidx == 2'd3) begin
                out_valid <= 1'b0;
                kidx      <= 2'd0;
                ridx      <= ridx + 4'd1;
                if (ridx == 4'd15) begin
                  done      <= 1'b1;
                  bcnt      <= 2'd0;
                  widx      <= 4'd0;
                  rcnt      <= 8'd0;
                  ridx      <= 4'd0;
                  core_addr <= 4'd0;
                  state     <= S_LOAD;
                end else begin
                  core_addr <= ridx + 4'd1;
                  state     <= S_RADDR;
                end
              end else begin
                kidx     <= kidx_nxt;
                out_byte <= out_word[{kidx_nxt, 3'b000} +: 8];
              end
            end
          end

          default: state <= S_LOAD;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chacha_host_seq.sv
// Self-checking bench for chacha_host_seq: a tiny core model with one cycle of
// read latency, a bus monitor that logs writes, round-enable runs and output
// bytes, and scenario tasks comparing those logs with an image-level model.
module tb_chacha_host_seq;

  localparam int ROUNDS = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        abort;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [3:0]  core_addr;
  logic [31:0] core_data_in;
  logic        core_write_n;
  logic        core_round_n;
  logic [31:0] core_data_out;

  int checks   = 0;
  int failures = 0;

  // Clock block
  always #5 clk = ~clk;

  chacha_host_seq #(.ROUNDS(ROUNDS), .READ_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .abort(abort),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done),
    .core_addr(core_addr), .core_data_in(core_data_in),
    .core_write_n(core_write_n), .core_round_n(core_round_n),
    .core_data_out(core_data_out)
  );

  // Core model: registered read, one cycle after the address settles.
  logic [31:0] core_mem [16];
  logic [31:0] core_rd = 32'd0;
  always @(posedge clk) core_rd <= core_mem[core_addr];
  assign core_data_out = core_rd;

  // Stimulus image and expected (scoreboard) queues.
  logic [7:0]  img [64];
  logic [35:0] exp_wr_q [$];
  logic [7:0]  exp_q [$];

  // Observed logs.
  logic [35:0] wr_q [$];
  int          round_q [$];
  logic [7:0]  got_q [$];
  int wr_wide_err = 0, stall_err = 0, done_err = 0, done_cnt = 0, round_run = 0;
  bit prev_wn_low = 0, stall_pending = 0, prev_busy = 0, prev_done = 0;
  logic [7:0] stall_byte = 8'd0;

  // Bus monitor sampling mid-cycle.
  always @(negedge clk) begin
    if (!core_write_n) begin
      wr_q.push_back({core_addr, core_data_in});
      if (prev_wn_low) wr_wide_err++;
    end
    prev_wn_low = !core_write_n;
    if (!core_round_n) round_run++;
    else if (round_run > 0) begin
      round_q.push_back(round_run);
      round_run = 0;
    end
    if (stall_pending && (out_valid !== 1'b1 || out_byte !== stall_byte)) stall_err++;
    stall_pending = rst_n && out_valid && !out_ready;
    stall_byte = out_byte;
    if (out_valid && out_ready) got_q.push_back(out_byte);
    if (done === 1'b1) begin
      done_cnt++;
      if (busy !== 1'b0 || !prev_busy || prev_done) done_err++;
    end
    prev_busy = busy;
    prev_done = done;
  end

  // Reference model: words are the image packed little-endian, written in
  // address order; the output is each core word's bytes, low byte first.
  function automatic void build_expected();
    logic [31:0] t;
    exp_wr_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++)
      exp_wr_q.push_back({4'(i), img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]});
    for (int a = 0; a < 16; a++)
      for (int k = 0; k < 4; k++) begin
        t = core_mem[a] >> (8 * k);
        exp_q.push_back(t[7:0]);
      end
  endfunction

  task automatic clear_mon();
    wr_q.delete();
    round_q.delete();
    got_q.delete();
    wr_wide_err = 0;
    stall_err = 0;
    done_err = 0;
  endtask

  // Driver: offer the 64-byte image, optionally with idle gaps.
  task automatic load_image(input bit gaps, output int edges);
    bit tr;
    bit ok;
    edges = 0;
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
          edges++;
        end
      end
      in_valid = 1'b1;
      in_byte  = img[i];
      ok = 0;
      for (int g = 0; g < 20; g++) begin
        tr = in_ready;
        @(posedge clk); #1;
        edges++;
        if (tr) begin ok = 1; break; end
      end
      if (!ok) begin
        checks++;
        failures++;
        $display("FAIL load_timeout byte=%0d in_ready stayed low", i);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Driver: accept output (always or at random) until done, bounded.
  task automatic drain(input bit rnd);
    bit got;
    got = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (done === 1'b1) begin got = 1; break; end
    end
    out_ready = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL drain_timeout done=%b required=1 within 3000 cycles", done);
    end
  endtask

  task automatic test_reset();
    checks += 9;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_byte !== 8'h00) begin failures++; $display("FAIL rst_out_byte got=%h exp=00", out_byte); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    if (core_write_n !== 1'b1) begin failures++; $display("FAIL rst_write_n got=%b exp=1", core_write_n); end
    if (core_round_n !== 1'b1) begin failures++; $display("FAIL rst_round_n got=%b exp=1", core_round_n); end
    if (core_addr !== 4'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", core_addr); end
    if (core_data_in !== 32'h0) begin failures++; $display("FAIL rst_data_in got=%h exp=0", core_data_in); end
  endtask

  task automatic test_load_order();
    int edges;
    int d0;
    for (int i = 0; i < 64; i++) img[i] = 8'(i);
    for (int a = 0; a < 16; a++) core_mem[a] = 32'(a) * 32'h01010101;
    build_expected();
    clear_mon();
    d0 = done_cnt;
    load_image(1'b0, edges);
    drain(1'b0);
    checks += 8;
    if (edges !== 79) begin failures++; $display("FAIL lo_throughput edges=%0d exp=79", edges); end
    if (wr_q.size() !== 16) begin failures++; $display("FAIL lo_write_count got=%0d exp=16", wr_q.size()); end
    if (wr_wide_err !== 0) begin failures++; $display("FAIL lo_write_width wide=%0d exp=0", wr_wide_err); end
    if (wr_q.size() > 15 && (wr_q[0][31:0] !== 32'h03020100 || wr_q[15][31:0] !== 32'h3F3E3D3C)) begin
      failures++; $display("FAIL lo_word0_15 got=%h,%h exp=03020100,3f3e3d3c", wr_q[0][31:0], wr_q[15][31:0]);
    end
    if (round_q.size() !== 1 || round_q[0] !== ROUNDS) begin
      failures++; $display("FAIL lo_rounds runs=%0d first=%0d exp 1 run of %0d", round_q.size(), round_q.size() ? round_q[0] : -1, ROUNDS);
    end
    if (done_cnt - d0 !== 1 || done_err !== 0) begin
      failures++; $display("FAIL lo_done pulses=%0d err=%0d exp 1,0", done_cnt - d0, done_err);
    end
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL lo_idle busy=%b in_ready=%b exp 0,1", busy, in_ready);
    end
    if (got_q.size() !== 64) begin failures++; $display("FAIL lo_out_count got=%0d exp=64", got_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_wr_q[i]) begin failures++; $display("FAIL lo_write%0d got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end
    end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL lo_out%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_stall();
    int edges;
    int d0;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    for (int a = 0; a < 16; a++) core_mem[a] = $urandom;
    build_expected();
    clear_mon();
    d0 = done_cnt;
    load_image(1'b1, edges);
    drain(1'b1);
    checks += 5;
    if (wr_q.size() !== 16 || wr_wide_err !== 0) begin
      failures++; $display("FAIL st_writes count=%0d wide=%0d exp 16,0", wr_q.size(), wr_wide_err);
    end
    if (round_q.size() !== 1 || round_q[0] !== ROUNDS) begin
      failures++; $display("FAIL st_rounds runs=%0d exp 1 run of %0d", round_q.size(), ROUNDS);
    end
    if (stall_err !== 0) begin failures++; $display("FAIL st_hold changes=%0d exp=0", stall_err); end
    if (got_q.size() !== 64) begin failures++; $display("FAIL st_out_count got=%0d exp=64", got_q.size()); end
    if (done_cnt - d0 !== 1 || done_err !== 0) begin
      failures++; $display("FAIL st_done pulses=%0d err=%0d exp 1,0", done_cnt - d0, done_err);
    end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_wr_q[i]) begin failures++; $display("FAIL st_write%0d got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end
    end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL st_out%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort_round();
    int edges;
    int d0;
    bit seen;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    clear_mon();
    d0 = done_cnt;
    load_image(1'b0, edges);
    seen = 0;
    for (int g = 0; g < 10; g++) begin
      if (core_round_n === 1'b0) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL ab_round_start round_n=%b exp=0", core_round_n); end
    repeat (6) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    checks += 4;
    if (core_round_n !== 1'b1) begin failures++; $display("FAIL ab_round_n got=%b exp=1", core_round_n); end
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL ab_load in_ready=%b busy=%b exp 1,0", in_ready, busy);
    end
    if (out_valid !== 1'b0 || core_write_n !== 1'b1) begin
      failures++; $display("FAIL ab_outputs out_valid=%b write_n=%b exp 0,1", out_valid, core_write_n);
    end
    repeat (3) begin @(posedge clk); #1; end
    if (done_cnt !== d0) begin failures++; $display("FAIL ab_no_done pulses=%0d exp=0", done_cnt - d0); end
    // Fresh load after the abort must complete normally from address 0.
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    for (int a = 0; a < 16; a++) core_mem[a] = $urandom;
    build_expected();
    wr_q.delete();
    got_q.delete();
    load_image(1'b0, edges);
    drain(1'b0);
    checks += 3;
    if (round_q.size() !== 2 || round_q[0] !== 7 || round_q[1] !== ROUNDS) begin
      failures++; $display("FAIL ab_round_runs runs=%0d exp runs 7 then %0d", round_q.size(), ROUNDS);
    end
    if (wr_q.size() !== 16) begin failures++; $display("FAIL ab_write_count got=%0d exp=16", wr_q.size()); end
    if (got_q.size() !== 64) begin failures++; $display("FAIL ab_out_count got=%0d exp=64", got_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_wr_q[i]) begin failures++; $display("FAIL ab_write%0d got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end
    end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ab_out%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_abort_load();
    int edges;
    clear_mon();
    // Two stale bytes, then a third offered together with abort.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      abort    = (i == 2);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    build_expected();
    load_image(1'b1, edges);
    drain(1'b0);
    checks++;
    if (wr_q.size() !== 16) begin failures++; $display("FAIL al_write_count got=%0d exp=16", wr_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_wr_q[i]) begin failures++; $display("FAIL al_write%0d got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end
    end
  endtask

  task automatic test_reset_emit();
    int edges;
    int d0;
    bit hit;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    for (int a = 0; a < 16; a++) core_mem[a] = $urandom;
    clear_mon();
    d0 = done_cnt;
    load_image(1'b0, edges);
    hit = 0;
    for (int c = 0; c < 3000; c++) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      if (got_q.size() == 20 && out_valid === 1'b1) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL re_reach_word5 bytes=%0d exp=20", got_q.size()); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL re_async out_valid=%b busy=%b exp 0,0", out_valid, busy);
    end
    if (core_write_n !== 1'b1 || core_round_n !== 1'b1) begin
      failures++; $display("FAIL re_core write_n=%b round_n=%b exp 1,1", core_write_n, core_round_n);
    end
    if (out_byte !== 8'h00 || core_addr !== 4'h0) begin
      failures++; $display("FAIL re_values out_byte=%h addr=%h exp 00,0", out_byte, core_addr);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks += 2;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL re_in_ready got=%b exp=1", in_ready); end
    if (done_cnt !== d0) begin failures++; $display("FAIL re_no_done pulses=%0d exp=0", done_cnt - d0); end
    // A full run after the reset must start writing at address 0.
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    build_expected();
    clear_mon();
    @(posedge clk); #1;
    load_image(1'b0, edges);
    drain(1'b1);
    checks += 2;
    if (wr_q.size() !== 16) begin failures++; $display("FAIL re_write_count got=%0d exp=16", wr_q.size()); end
    if (got_q.size() !== 64) begin failures++; $display("FAIL re_out_count got=%0d exp=64", got_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_wr_q[i]) begin failures++; $display("FAIL re_write%0d got=%h exp=%h", i, wr_q[i], exp_wr_q[i]); end
    end
    for (int i = 0; i < 64 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL re_out%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  // Reset block and test sequence, then the report.
  initial begin
    rst_n     = 1'b0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    for (int a = 0; a < 16; a++) core_mem[a] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    test_reset();
    @(posedge clk); #1;
    test_load_order();
    test_random_stall();
    test_random_stall();
    test_abort_round();
    test_abort_load();
    test_reset_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
